// File: rtl/alu_md_ctrl.sv
// ALU control decoder (RV32I R/I-type) plus an iterative RV32M multiply/divide
// sequencer that stalls the pipeline until its result is ready.
module alu_md_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ALUop,
    input  logic [6:0]      func7,
    input  logic [2:0]      func3,
    input  logic            in_valid,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            md_flush,
    output logic [3:0]      alu_opcode,
    output logic            md_sel,
    output logic            md_stall,
    output logic            md_busy,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_b;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [3:0]          w_f3_op;

    // func3 map shared by R-type and I-type; func7[5] picks SRA for shifts right
    always_comb begin
        w_f3_op = OP_ADD;
        case (func3)
            3'b001:  w_f3_op = OP_SLL;
            3'b010:  w_f3_op = OP_SLT;
            3'b011:  w_f3_op = OP_SLTU;
            3'b100:  w_f3_op = OP_XOR;
            3'b101:  w_f3_op = func7[5] ? OP_SRA : OP_SRL;
            3'b110:  w_f3_op = OP_OR;
            3'b111:  w_f3_op = OP_AND;
            default: w_f3_op = OP_ADD;
        endcase
    end

    always_comb begin
        alu_opcode = OP_ADD;
        case (ALUop)
            2'b01: alu_opcode = OP_SUB;
            2'b10: begin
                if (func7 == 7'b0000000 || func7 == 7'b0100000)
                    alu_opcode = (func3 == 3'b000 && func7[5]) ? OP_SUB : w_f3_op;
            end
            2'b11:   alu_opcode = w_f3_op;
            default: alu_opcode = OP_ADD;
        endcase
    end

    assign md_sel = (ALUop == 2'b10) && (func7 == 7'b0000001);

    logic            w_accept, w_div, w_dz, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;

    assign w_accept = (r_state == S_IDLE) && in_valid && md_sel && !md_flush;
    assign w_div    = func3[2];
    assign w_dz     = w_div && (op_b == '0);
    // Signed operands: MULH/MULHSU/DIV/REM for a; MULH/DIV/REM for b
    assign w_a_sgn  = (func3 == 3'b001) || (func3 == 3'b010) || (func3 == 3'b100) || (func3 == 3'b110);
    assign w_b_sgn  = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
    assign w_a_neg  = w_a_sgn && op_a[XLEN-1];
    assign w_b_neg  = w_b_sgn && op_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -op_a : op_a;
    assign w_b_mag  = w_b_neg ? -op_b : op_b;

    // Multiply step: add multiplicand into the high half, shift the product right
    logic [XLEN:0]     w_mul_sum;
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);

    // Restoring divide step: {rem, dividend} shifts left, quotient bits enter at LSB
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_sub, w_rem_nx;
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge      = w_rem_sh >= {1'b0, r_b};
    assign w_rem_sub = w_rem_sh[XLEN-1:0] - r_b;
    assign w_rem_nx  = w_ge ? w_rem_sub : w_rem_sh[XLEN-1:0];

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_dsel, w_dres, w_fix_res;
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_dsel    = r_op[1] ? r_acc[2*XLEN-1:XLEN] : r_acc[XLEN-1:0];
    assign w_dres    = r_neg ? -w_dsel : w_dsel;
    assign w_fix_res = r_op[2] ? w_dres :
                       (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = w_dz ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CNT_W'(1)) w_state_nx = S_FIX;
            S_FIX:   w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (md_flush && r_state != S_IDLE) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            md_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op  <= func3;
                    r_b   <= w_b_mag;
                    r_cnt <= CNT_W'(XLEN);
                    // Divide-by-zero preloads quotient=all ones, remainder=raw op_a
                    r_acc <= w_dz ? {op_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, w_a_mag};
                    r_neg <= w_dz ? 1'b0 :
                             (w_div && func3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    r_acc <= r_op[2] ? {w_rem_nx, r_acc[XLEN-2:0], w_ge}
                                     : {w_mul_sum, r_acc[XLEN-1:1]};
                end
                S_FIX: if (!md_flush) md_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign md_busy  = (r_state != S_IDLE);
    assign md_done  = (r_state == S_DONE) && !md_flush;
    assign md_stall = in_valid && md_sel && !md_done;

endmodule

// File: tb/tb_alu_md_ctrl.sv
// Self-checking bench for alu_md_ctrl: decoder sweep, directed and random M-ops
// against a 64-bit arithmetic model, handshake timing, flush and async reset.
module tb_alu_md_ctrl;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [1:0]      ALUop = 2'b00;
    logic [6:0]      func7 = '0;
    logic [2:0]      func3 = '0;
    logic            in_valid = 1'b0;
    logic [XLEN-1:0] op_a = '0, op_b = '0;
    logic            md_flush = 1'b0;
    logic [3:0]      alu_opcode;
    logic            md_sel, md_stall, md_busy, md_done;
    logic [XLEN-1:0] md_result;

    int tests = 0;
    int fails = 0;

    alu_md_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .ALUop(ALUop), .func7(func7), .func3(func3),
        .in_valid(in_valid), .op_a(op_a), .op_b(op_b), .md_flush(md_flush),
        .alu_opcode(alu_opcode), .md_sel(md_sel), .md_stall(md_stall),
        .md_busy(md_busy), .md_done(md_done), .md_result(md_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference decoder written from the opcode table by instruction class
    function automatic logic [3:0] dec_ref(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3);
        logic [3:0] tbl [8];
        logic [3:0] r;
        tbl = '{4'd2, 4'd4, 4'd7, 4'd8, 4'd3, 4'd5, 4'd1, 4'd0};
        r = 4'd2;
        if (aop == 2'd1) r = 4'd6;
        else if (aop == 2'd2 && (f7 == 7'h00 || f7 == 7'h20)) begin
            r = tbl[f3];
            if (f7 == 7'h20 && f3 == 3'd0) r = 4'd6;
            if (f7 == 7'h20 && f3 == 3'd5) r = 4'd9;
        end else if (aop == 2'd3) begin
            r = tbl[f3];
            if (f3 == 3'd5 && f7[5]) r = 4'd9;
        end
        return r;
    endfunction

    // Reference M-extension result via 64-bit arithmetic
    function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0] ua, ub, up;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (f3)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * $signed(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                sp = sa % sb; return sp[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Present one M instruction from a negedge until done; check timing and result
    task automatic run_md(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int dcyc = -1, npulse = 0, stall_bad = 0, expc;
        logic [31:0] exp, res = '0;
        logic busy_after;
        exp  = md_ref(f3, a, b);
        expc = (f3[2] && b == 0) ? 2 : XLEN + 2;
        ALUop = 2'b10; func7 = 7'b0000001; func3 = f3; op_a = a; op_b = b; in_valid = 1'b1;
        #1 if (md_stall !== 1'b1) stall_bad++;
        for (int c = 1; c <= expc + 1; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 1) begin op_a = $urandom; op_b = $urandom; end
            if (md_done === 1'b1) begin
                npulse++;
                if (dcyc < 0) begin dcyc = c; res = md_result; end
            end
            if (c < expc && md_stall !== 1'b1) stall_bad++;
            if (c == expc && md_stall !== 1'b0) stall_bad++;
        end
        busy_after = md_busy;
        in_valid = 1'b0;
        chk({tag, " done_cycle"}, dcyc, expc);
        chk({tag, " result"}, res, exp);
        chk({tag, " done_pulses"}, npulse, 1);
        chk({tag, " stall_profile"}, stall_bad, 0);
        chk({tag, " busy_fall"}, {31'd0, busy_after}, 0);
        @(posedge clk); @(negedge clk);
        chk({tag, " result_hold"}, md_result, exp);
    endtask

    initial begin
        logic [1:0] aop;
        logic [6:0] f7;
        logic [2:0] f3;
        logic [31:0] a, b, prev;
        int npulse;

        #12;
        chk("reset busy", {31'd0, md_busy}, 0);
        chk("reset done", {31'd0, md_done}, 0);
        chk("reset result", md_result, 0);
        @(negedge clk); reset = 1'b0;

        // Decoder: directed then random
        ALUop = 2'b10; func7 = 7'h20; func3 = 3'd0; #1 chk("dec R sub", alu_opcode, 4'b0110);
        ALUop = 2'b11; func7 = 7'h20; func3 = 3'd0; #1 chk("dec I add", alu_opcode, 4'b0010);
        ALUop = 2'b11; func7 = 7'h20; func3 = 3'd5; #1 chk("dec I sra", alu_opcode, 4'b1001);
        ALUop = 2'b10; func7 = 7'h03; func3 = 3'd5; #1 chk("dec R bad f7", alu_opcode, 4'b0010);
        ALUop = 2'b00; func7 = 7'h55; func3 = 3'd7; #1 chk("dec ld/st", alu_opcode, 4'b0010);
        ALUop = 2'b01; func7 = 7'h00; func3 = 3'd4; #1 chk("dec branch", alu_opcode, 4'b0110);
        for (int i = 0; i < 60; i++) begin
            aop = 2'($urandom_range(0, 3));
            f3  = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            ALUop = aop; func7 = f7; func3 = f3; #1;
            chk("dec rnd op", alu_opcode, dec_ref(aop, f7, f3));
            chk("dec rnd md_sel", {31'd0, md_sel}, (aop == 2'd2 && f7 == 7'h01) ? 1 : 0);
        end
        @(negedge clk);

        // Directed M-ops
        run_md("MUL",    3'd0, 32'hFFFF_FFFF, 32'd3);
        run_md("MULH",   3'd1, 32'hFFFF_FFFF, 32'd3);
        run_md("MULHU",  3'd3, 32'hFFFF_FFFF, 32'd3);
        run_md("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd3);
        run_md("DIV",    3'd4, 32'hFFFF_FFF9, 32'd2);
        run_md("REM",    3'd6, 32'hFFFF_FFF9, 32'd2);
        run_md("DIVU",   3'd5, 32'hFFFF_FFF9, 32'd2);
        run_md("REMU",   3'd7, 32'hFFFF_FFF9, 32'd2);
        run_md("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md("DIVU dz", 3'd5, 32'd5, 32'd0);
        run_md("REM dz",  3'd6, 32'd5, 32'd0);
        run_md("REM neg", 3'd6, 32'd7, 32'hFFFF_FFFE);

        // Flush mid-CALC: no done, result untouched
        prev = md_result;
        ALUop = 2'b10; func7 = 7'h01; func3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; in_valid = 1'b1;
        npulse = 0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); @(negedge clk);
            if (md_done === 1'b1) npulse++;
            if (c == 10) begin md_flush = 1'b1; in_valid = 1'b0; end
            if (c == 11) begin
                md_flush = 1'b0;
                chk("flush busy", {31'd0, md_busy}, 0);
            end
        end
        chk("flush no done", npulse, 0);
        chk("flush result kept", md_result, prev);

        // Flush coincident with an accept in IDLE: flush wins
        ALUop = 2'b10; func7 = 7'h01; func3 = 3'd0; in_valid = 1'b1; md_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; md_flush = 1'b0;
        chk("flush blocks accept", {31'd0, md_busy}, 0);

        // Random M-ops including corner operands
        for (int i = 0; i < 20; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_md("rnd", f3, a, b);
        end

        // Async reset mid-operation
        ALUop = 2'b10; func7 = 7'h01; func3 = 3'd0; op_a = $urandom | 32'h1; op_b = 32'd3; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); @(negedge clk); end
        reset = 1'b1; in_valid = 1'b0;
        #1;
        chk("rst mid busy", {31'd0, md_busy}, 0);
        chk("rst mid done", {31'd0, md_done}, 0);
        chk("rst mid result", md_result, 0);
        chk("rst mid stall", {31'd0, md_stall}, 0);
        @(negedge clk); reset = 1'b0;
        run_md("post rst MUL", 3'd0, 32'd12345, 32'd678);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
